// File: rtl/boreal_dbg_pkg.sv
// Shared definitions for the Boreal debug UART bridge.
//   CMD_READ_PFX : upper five bits of a READ command byte (low three bits = address)
//   NAK_BYTE     : reply sent for any byte that is not a READ command
//   main_state_t : command FSM encoding (ST_TX_CK only with BOREAL_DBG_CKSUM_EN)
//   rx_state_t   : serial receiver encoding
//   os_tick_div  : clocks per 16x oversample tick, rounded to nearest
//   is_read_cmd  : command decode helper
// Configuration macro: BOREAL_DBG_CKSUM_EN
package boreal_dbg_pkg;

   localparam logic [4:0] CMD_READ_PFX = 5'b10100;
   localparam logic [7:0] NAK_BYTE     = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_TX_HI,
      ST_TX_LO,
`ifdef BOREAL_DBG_CKSUM_EN
      ST_TX_NAK,
      ST_TX_CK
`else
      ST_TX_NAK
`endif
   } main_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic int os_tick_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + baud * 8) / (baud * 16);
      return (d < 1) ? 1 : d;
   endfunction

   function automatic logic is_read_cmd(input logic [7:0] b);
      return b[7:3] == CMD_READ_PFX;
   endfunction

endpackage

// File: rtl/boreal_uart_rx.sv
// 8N1 serial receiver with 16x oversampling.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : raw serial input, idle high, asynchronous to clk
//   byte_data   : last received byte (stable after byte_valid)
//   byte_valid  : one-cycle pulse when a byte with a good stop bit arrives
//   frame_err   : sticky, set when a stop bit is sampled low
module boreal_uart_rx
   import boreal_dbg_pkg::*;
#(
   parameter int DIV = 54
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   logic [1:0]  sync;
   logic        rx_s;
   logic [15:0] div_cnt;
   logic        tick;
   rx_state_t   state, state_next;
   logic [3:0]  tick_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;

   assign rx_s      = sync[1];
   assign tick      = (div_cnt == 16'(DIV - 1));
   assign byte_data = shreg;

   always_comb begin
      state_next = state;
      if (tick) begin
         case (state)
            RX_IDLE:  if (!rx_s) state_next = RX_START;
            // A start edge must still be low half a bit later, otherwise it was a glitch.
            RX_START: if (tick_cnt == 4'd7) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_cnt == 4'd15 && bit_cnt == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (tick_cnt == 4'd15) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= 2'b11;
         div_cnt    <= '0;
         state      <= RX_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[0], rx};
         div_cnt    <= tick ? 16'd0 : div_cnt + 16'd1;
         byte_valid <= 1'b0;
         state      <= state_next;
         if (tick) begin
            case (state)
               RX_IDLE: tick_cnt <= '0;
               RX_START: begin
                  tick_cnt <= (tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;
                  bit_cnt  <= '0;
               end
               RX_DATA: begin
                  // Counter wraps every 16 ticks, so each sample lands mid-bit.
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     shreg   <= {rx_s, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               RX_STOP: begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     if (rx_s) byte_valid <= 1'b1;
                     else      frame_err  <= 1'b1;
                  end
               end
               default: tick_cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: rtl/boreal_dbg_uart_bridge.sv
// UART host bridge for the Boreal debug status register bus.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   uart_rx       : host->bridge serial (8N1)
//   uart_tx       : bridge->host serial (8N1), idle high
//   dbg_addr      : register address, held until the next read
//   dbg_rd_en     : one-cycle read strobe
//   dbg_rd_data   : read data, sampled RD_LAT cycles after dbg_rd_en
//   busy          : command accepted or pending, until the last stop bit ends
//   rx_frame_err  : sticky RX framing error
//   rx_overrun    : sticky, a command was dropped because the pending slot was full
// Configuration macro: BOREAL_DBG_CKSUM_EN appends cmd^hi^lo to READ replies.
module boreal_dbg_uart_bridge
   import boreal_dbg_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115_200,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic [2:0]  dbg_addr,
   output logic        dbg_rd_en,
   input  logic [15:0] dbg_rd_data,
   output logic        busy,
   output logic        rx_frame_err,
   output logic        rx_overrun
);

   localparam int          DIV      = os_tick_div(CLK_HZ, BAUD);
   localparam logic [15:0] BIT_LAST = 16'(DIV * 16 - 1);

   logic [7:0]  rx_byte;
   logic        rx_valid;
   main_state_t state, state_next;
   logic        pend_valid;
   logic [7:0]  pend_byte;
   logic [7:0]  cmd_sel;
   logic        dispatch;
   logic [2:0]  wait_cnt;
   logic [15:0] word_reg;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic        tx_active;
   logic [9:0]  tx_sr;
   logic [3:0]  tx_bit;
   logic [15:0] tx_cyc;
`ifdef BOREAL_DBG_CKSUM_EN
   logic [7:0]  cmd_reg;
`endif

   boreal_uart_rx #(.DIV(DIV)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (uart_rx),
      .byte_data  (rx_byte),
      .byte_valid (rx_valid),
      .frame_err  (rx_frame_err)
   );

   // A queued command always goes ahead of one arriving in the same cycle.
   assign cmd_sel = pend_valid ? pend_byte : rx_byte;
   assign busy    = (state != ST_IDLE) || pend_valid;
   assign uart_tx = tx_sr[0];
   assign tx_done = tx_active && (tx_cyc == BIT_LAST) && (tx_bit == 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Each TX state covers one byte on the wire; the next byte is started in the
   // last cycle of the previous stop bit so reply bytes run back to back.
   always_comb begin
      state_next = state;
      dispatch   = 1'b0;
      dbg_rd_en  = 1'b0;
      tx_start   = 1'b0;
      tx_byte    = word_reg[15:8];
      case (state)
         ST_IDLE: begin
            if (pend_valid || rx_valid) begin
               dispatch = 1'b1;
               if (is_read_cmd(cmd_sel)) begin
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_TX_NAK;
                  tx_start   = 1'b1;
                  tx_byte    = NAK_BYTE;
               end
            end
         end
         ST_ISSUE: begin
            dbg_rd_en  = 1'b1;
            state_next = (RD_LAT == 1) ? ST_CAPTURE : ST_WAIT;
         end
         ST_WAIT: if (wait_cnt <= 3'd1) state_next = ST_CAPTURE;
         ST_CAPTURE: begin
            tx_start   = 1'b1;
            tx_byte    = dbg_rd_data[15:8];
            state_next = ST_TX_HI;
         end
         ST_TX_HI: begin
            if (tx_done) begin
               tx_start   = 1'b1;
               tx_byte    = word_reg[7:0];
               state_next = ST_TX_LO;
            end
         end
         ST_TX_LO: begin
            if (tx_done) begin
`ifdef BOREAL_DBG_CKSUM_EN
               tx_start   = 1'b1;
               tx_byte    = cmd_reg ^ word_reg[15:8] ^ word_reg[7:0];
               state_next = ST_TX_CK;
`else
               state_next = ST_IDLE;
`endif
            end
         end
`ifdef BOREAL_DBG_CKSUM_EN
         ST_TX_CK: if (tx_done) state_next = ST_IDLE;
`endif
         ST_TX_NAK: if (tx_done) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_byte  <= '0;
         rx_overrun <= 1'b0;
         dbg_addr   <= '0;
         wait_cnt   <= '0;
         word_reg   <= '0;
`ifdef BOREAL_DBG_CKSUM_EN
         cmd_reg    <= '0;
`endif
      end else begin
         if (dispatch && is_read_cmd(cmd_sel)) begin
            dbg_addr <= cmd_sel[2:0];
`ifdef BOREAL_DBG_CKSUM_EN
            cmd_reg  <= cmd_sel;
`endif
         end
         if (rx_valid) begin
            if (state == ST_IDLE) begin
               // Pending is being served now, so the new byte takes its slot.
               if (pend_valid) pend_byte <= rx_byte;
            end else if (!pend_valid) begin
               pend_valid <= 1'b1;
               pend_byte  <= rx_byte;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (state == ST_IDLE && pend_valid) begin
            pend_valid <= 1'b0;
         end
         if (state == ST_ISSUE)   wait_cnt <= 3'(RD_LAT - 1);
         else if (state == ST_WAIT) wait_cnt <= wait_cnt - 3'd1;
         if (state == ST_CAPTURE) word_reg <= dbg_rd_data;
      end
   end

   // TX shifter: frame {stop, data, start} shifted out LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr     <= '1;
         tx_bit    <= '0;
         tx_cyc    <= '0;
         tx_active <= 1'b0;
      end else if (tx_start) begin
         tx_sr     <= {1'b1, tx_byte, 1'b0};
         tx_bit    <= '0;
         tx_cyc    <= '0;
         tx_active <= 1'b1;
      end else if (tx_active) begin
         if (tx_cyc == BIT_LAST) begin
            tx_cyc <= '0;
            tx_sr  <= {1'b1, tx_sr[9:1]};
            if (tx_bit == 4'd9) tx_active <= 1'b0;
            else                tx_bit    <= tx_bit + 4'd1;
         end else begin
            tx_cyc <= tx_cyc + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_boreal_dbg_uart_bridge.sv
// Self-checking bench for boreal_dbg_uart_bridge: randomized and directed host
// commands, a reference reply model feeding a scoreboard, and independent
// monitors on the serial output and the debug read bus.
module tb_boreal_dbg_uart_bridge;

   localparam int CLK_HZ = 64_000_000;
   localparam int BAUD   = 1_000_000;
   localparam int RD_LAT = 3;
   localparam int BITC   = 64;   // clocks per serial bit at this CLK_HZ/BAUD

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic [2:0]  dbg_addr;
   logic        dbg_rd_en;
   logic [15:0] dbg_rd_data = 16'h0;
   logic        busy;
   logic        rx_frame_err;
   logic        rx_overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [2:0]  addr_q[$];
   logic [15:0] mem[8];
   bit          mon_active = 0;

   boreal_dbg_uart_bridge #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RD_LAT(RD_LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .uart_tx      (uart_tx),
      .dbg_addr     (dbg_addr),
      .dbg_rd_en    (dbg_rd_en),
      .dbg_rd_data  (dbg_rd_data),
      .busy         (busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: what the host should see for one command byte.
   task automatic expect_cmd(input logic [7:0] b);
      logic [2:0]  a;
      logic [15:0] w;
      if (b[7:3] == 5'b10100) begin
         a = b[2:0];
         w = mem[a];
         addr_q.push_back(a);
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
`ifdef BOREAL_DBG_CKSUM_EN
         exp_q.push_back(b ^ w[15:8] ^ w[7:0]);
`endif
         $display("cmd %02h read addr %0d word %04h", b, a, w);
      end else begin
         exp_q.push_back(8'hEE);
         $display("cmd %02h nak", b);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BITC) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (BITC) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", 32'(n < budget), 32'd1);
      repeat (48) @(negedge clk);
   endtask

   // Serial output monitor: decode each frame mid-bit and score it.
   initial begin : tx_monitor
      int          cnt;
      int          k;
      logic [7:0]  sh;
      cnt = 0;
      sh  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_active = 0;
         end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
               mon_active = 1;
               cnt = 0;
            end
         end else begin
            cnt++;
            if (cnt % BITC == BITC / 2) begin
               k = cnt / BITC;
               if (k == 0) begin
                  chk("tx_start_bit", 32'(uart_tx), 32'd0);
               end else if (k <= 8) begin
                  sh[k-1] = uart_tx;
               end else begin
                  chk("tx_stop_bit", 32'(uart_tx), 32'd1);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL tx_unexpected actual=%02h expected=none", sh);
                  end else begin
                     chk("tx_byte", 32'(sh), 32'(exp_q.pop_front()));
                     $display("tx byte %02h", sh);
                  end
                  mon_active = 0;
               end
            end
         end
      end
   end

   // Debug bus: check each strobe, and return data only RD_LAT cycles later.
   initial begin : bus_model
      bit         hist_en[8];
      logic [2:0] hist_addr[8];
      bit         prev_en;
      prev_en = 0;
      for (int i = 0; i < 8; i++) begin
         hist_en[i] = 0;
         hist_addr[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 7; i > 0; i--) begin
            hist_en[i]   = hist_en[i-1];
            hist_addr[i] = hist_addr[i-1];
         end
         hist_en[0]   = rst_n && (dbg_rd_en === 1'b1);
         hist_addr[0] = dbg_addr;
         if (hist_en[0]) begin
            chk("rd_en_one_cycle", 32'(prev_en), 32'd0);
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected actual=addr %0d expected=no read", dbg_addr);
            end else begin
               chk("rd_addr", 32'(dbg_addr), 32'(addr_q.pop_front()));
            end
         end
         prev_en = hist_en[0];
         if (hist_en[RD_LAT]) dbg_rd_data = mem[hist_addr[RD_LAT]];
         else                 dbg_rd_data = 16'($urandom);
      end
   end

   initial begin : watchdog
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [7:0] b;
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);

      // 1: reset and idle line
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2000) @(negedge clk);
      chk("reset_uart_tx", 32'(uart_tx), 32'd1);
      chk("reset_rd_en", 32'(dbg_rd_en), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_addr", 32'(dbg_addr), 32'd0);
      chk("reset_frame_err", 32'(rx_frame_err), 32'd0);
      chk("reset_overrun", 32'(rx_overrun), 32'd0);

      // 2: read of address 3
      mem[3] = 16'h1234;
      expect_cmd(8'hA3);
      send_byte(8'hA3, 1'b1);
      chk("busy_during_reply", 32'(busy), 32'd1);
      wait_quiet(4000);
      chk("busy_after_read", 32'(busy), 32'd0);
      chk("read_issued", 32'(addr_q.size()), 32'd0);

      // 3: non-command byte
      expect_cmd(8'h42);
      send_byte(8'h42, 1'b1);
      wait_quiet(4000);
      chk("busy_after_nak", 32'(busy), 32'd0);

      // 4: framing error, no reply
      send_byte(8'hA1, 1'b0);
      repeat (BITC * 12) @(negedge clk);
      chk("frame_err_set", 32'(rx_frame_err), 32'd1);
      chk("busy_after_frame_err", 32'(busy), 32'd0);

      // 5: three commands back to back, third one dropped
      expect_cmd(8'hA0);
      expect_cmd(8'hA1);
      $display("cmd a2 expected to be dropped");
      send_byte(8'hA0, 1'b1);
      send_byte(8'hA1, 1'b1);
      send_byte(8'hA2, 1'b1);
      wait_quiet(8000);
      chk("overrun_set", 32'(rx_overrun), 32'd1);
      chk("frame_err_sticky", 32'(rx_frame_err), 32'd1);

      // randomized commands with the bus contents refreshed between them
      for (int n = 0; n < 10; n++) begin
         mem[$urandom_range(0, 7)] = 16'($urandom);
         if ($urandom_range(0, 1) == 1) b = {5'b10100, 3'($urandom_range(0, 7))};
         else                           b = 8'($urandom);
         expect_cmd(b);
         send_byte(b, 1'b1);
         wait_quiet(6000);
         repeat ($urandom_range(0, 100)) @(negedge clk);
      end
      chk("overrun_still_set", 32'(rx_overrun), 32'd1);

      // 6: reset in the middle of the high reply byte
      addr_q.push_back(3'd6);
      $display("cmd a6 read addr 6, reply aborted by reset");
      send_byte(8'hA6, 1'b1);
      repeat (200) @(negedge clk);
      chk("busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_uart_tx", 32'(uart_tx), 32'd1);
      chk("midreset_frame_err", 32'(rx_frame_err), 32'd0);
      chk("midreset_overrun", 32'(rx_overrun), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_read_done", 32'(addr_q.size()), 32'd0);
      exp_q.delete();
      addr_q.delete();
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      expect_cmd(8'hA5);
      send_byte(8'hA5, 1'b1);
      wait_quiet(4000);
      chk("after_reset_busy", 32'(busy), 32'd0);
      chk("after_reset_frame_err", 32'(rx_frame_err), 32'd0);
      chk("after_reset_overrun", 32'(rx_overrun), 32'd0);
      chk("all_reads_seen", 32'(addr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
